// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a guard cycle per slot,
// tear-free frame latching and per-digit blinking.
module ssd_scan_ctrl #(
    parameter int          REFRESH_DIV = 100000,
    parameter int          BLINK_DIV   = 50000000,
    parameter logic [4:0]  BLANK       = 5'b11111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [19:0] ssd_in,
    input  logic [3:0]  blink_mask,
    input  logic        blink_restart,
    output logic [3:0]  an,
    output logic [4:0]  digit_code,
    output logic        blink_phase
);
    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 5;
    localparam int RCNT_W     = $clog2(REFRESH_DIV);
    localparam int BCNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);

    logic [RCNT_W-1:0]                  rcnt;
    logic [1:0]                         slot;
    logic [NUM_DIGITS-1:0][DIG_W-1:0]   frame;
    logic [BCNT_W-1:0]                  bcnt;
    logic                               slot_end;
    logic                               scan_on;
    logic [NUM_DIGITS-1:0]              dig_on;

    assign slot_end = (rcnt == RCNT_LAST);

    // frame[3] is the leftmost digit and is shown in slot 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt  <= '0;
            slot  <= '0;
            frame <= {NUM_DIGITS{BLANK}};
        end else if (en) begin
            if (slot_end) begin
                rcnt <= '0;
                slot <= slot + 2'd1;
                if (slot == 2'd3)
                    frame <= ssd_in;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    // Blink timebase free-runs regardless of en; restart wins over terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (blink_restart) begin
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (bcnt == BCNT_LAST) begin
            bcnt        <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    // rcnt==0 is the guard cycle that keeps anodes off while the code switches
    assign scan_on = en && (rcnt != '0);

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        assign dig_on[d] = scan_on && (slot == 2'(NUM_DIGITS - 1 - d))
                           && !(blink_mask[d] && blink_phase);
        assign an[d]     = ~dig_on[d];
    end

    always_comb begin
        digit_code = BLANK;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (dig_on[d])
                digit_code = frame[d];
    end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: scan table, directed corner cases and
// randomized traffic against a slot/position reference model.
module tb_ssd_scan_ctrl;
    localparam int         RD = 4;
    localparam int         BD = 8;
    localparam logic [4:0] BL = 5'b11111;
    localparam logic [19:0] PAT  = {5'd1, 5'd2, 5'd3, 5'd4};
    localparam logic [19:0] NEWP = {5'd9, 5'd10, 5'd11, 5'd12};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [19:0] ssd_in;
    logic [3:0]  blink_mask;
    logic        blink_restart;
    logic [3:0]  an;
    logic [4:0]  digit_code;
    logic        blink_phase;

    ssd_scan_ctrl #(.REFRESH_DIV(RD), .BLINK_DIV(BD), .BLANK(BL)) dut (
        .clk(clk), .rst(rst), .en(en), .ssd_in(ssd_in), .blink_mask(blink_mask),
        .blink_restart(blink_restart), .an(an), .digit_code(digit_code),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: position within a 4*RD-cycle scan, codes indexed by slot
    int         m_pos;
    int         m_bt;
    logic       m_ph;
    logic [4:0] m_frame [4];

    typedef struct {
        logic [3:0] ea;
        logic [4:0] ec;
    } vec_t;
    vec_t tbl [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_bt  = 0;
        m_ph  = 1'b0;
        for (int k = 0; k < 4; k++) m_frame[k] = BL;
    endtask

    task automatic model_exp(output logic [3:0] ea, output logic [4:0] ec);
        int s, r;
        s  = m_pos / RD;
        r  = m_pos % RD;
        ea = 4'hF;
        ec = BL;
        if (en && r != 0 && !(blink_mask[3-s] && m_ph)) begin
            ea[3-s] = 1'b0;
            ec      = m_frame[s];
        end
    endtask

    task automatic model_clk();
        if (en) begin
            if (m_pos == 4*RD - 1)
                for (int k = 0; k < 4; k++) m_frame[k] = ssd_in[19-5*k -: 5];
            m_pos = (m_pos + 1) % (4*RD);
        end
        if (blink_restart) begin
            m_bt = 0;
            m_ph = 1'b0;
        end else if (m_bt == BD - 1) begin
            m_bt = 0;
            m_ph = ~m_ph;
        end else begin
            m_bt++;
        end
    endtask

    task automatic drive_chk(input logic e, input logic [19:0] d, input logic [3:0] m, input logic rs);
        logic [3:0] ea;
        logic [4:0] ec;
        en = e; ssd_in = d; blink_mask = m; blink_restart = rs;
        #1;
        model_exp(ea, ec);
        chk("an", an, ea);
        chk("digit_code", digit_code, ec);
        chk("blink_phase", blink_phase, m_ph);
        chk("an_onehot", ($countones(~an) <= 1), 1);
    endtask

    task automatic adv();
        @(posedge clk);
        model_clk();
        @(negedge clk);
    endtask

    task automatic cyc(input logic e, input logic [19:0] d, input logic [3:0] m, input logic rs);
        drive_chk(e, d, m, rs);
        adv();
    endtask

    initial begin
        logic [3:0] one;
        bit found;
        one = 4'b1000;
        // First scan shows the reset frame (BLANK codes, anodes still driven), then PAT
        for (int i = 0; i < 32; i++) begin
            int k, r;
            k = (i % 16) / 4;
            r = i % 4;
            tbl[i].ea = (r == 0) ? 4'hF : ~(one >> k);
            tbl[i].ec = (r == 0 || i < 16) ? BL : 5'(k + 1);
        end

        rst = 1'b1; en = 1'b1; ssd_in = PAT; blink_mask = 4'h0; blink_restart = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_an", an, 4'hF);
        chk("reset_code", digit_code, BL);
        chk("reset_phase", blink_phase, 0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive_chk(1'b1, PAT, 4'h0, 1'b0);
            chk($sformatf("tbl_an[%0d]", i), an, tbl[i].ea);
            chk($sformatf("tbl_code[%0d]", i), digit_code, tbl[i].ec);
            adv();
        end

        // Blink on the slot-1 digit across several half-periods
        for (int i = 0; i < 40; i++) cyc(1'b1, PAT, 4'b0100, 1'b0);

        // Restart coinciding with the terminal count while phase is 0
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_bt == BD - 1 && m_ph == 1'b0) found = 1;
            else cyc(1'b1, PAT, 4'b0100, 1'b0);
        end
        chk("restart_reach", found, 1);
        cyc(1'b1, PAT, 4'b0100, 1'b1);
        #1 chk("restart_no_toggle", blink_phase, 0);
        for (int i = 0; i < 10; i++) cyc(1'b1, PAT, 4'b0100, 1'b0);

        // en low for 10 cycles mid slot 2, then resume in the same slot
        found = 0;
        for (int i = 0; i < 32 && !found; i++) begin
            if (m_pos == 2*RD + 1) found = 1;
            else cyc(1'b1, PAT, 4'h0, 1'b0);
        end
        chk("en_reach", found, 1);
        for (int i = 0; i < 10; i++) begin
            drive_chk(1'b0, PAT, 4'h0, 1'b0);
            chk("en_off_an", an, 4'hF);
            chk("en_off_code", digit_code, BL);
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            drive_chk(1'b1, PAT, 4'h0, 1'b0);
            chk("en_resume_an", an, 4'b1101);
            chk("en_resume_code", digit_code, 5'd3);
            adv();
        end

        // Tear-free: new codes arrive during slot 1, appear only from next slot 0
        found = 0;
        for (int i = 0; i < 32 && !found; i++) begin
            if (m_pos == RD + 1) found = 1;
            else cyc(1'b1, PAT, 4'h0, 1'b0);
        end
        chk("tear_reach", found, 1);
        for (int i = 0; i < 16; i++) begin
            drive_chk(1'b1, NEWP, 4'h0, 1'b0);
            if (m_pos == 3*RD + 2) chk("tear_old_code", digit_code, 5'd4);
            if (m_pos == 2)        chk("tear_new_code", digit_code, 5'd9);
            adv();
        end

        // Async reset between edges during slot 3
        found = 0;
        for (int i = 0; i < 32 && !found; i++) begin
            if (m_pos == 3*RD + 2) found = 1;
            else cyc(1'b1, NEWP, 4'h0, 1'b0);
        end
        chk("rst_reach", found, 1);
        drive_chk(1'b1, NEWP, 4'h0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_code", digit_code, BL);
        chk("async_rst_phase", blink_phase, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_chk(1'b1, NEWP, 4'h0, 1'b0);
            chk("post_rst_blank", digit_code, BL);
            adv();
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, NEWP, 4'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 9) != 0), 20'($urandom), 4'($urandom),
                ($urandom_range(0, 19) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
